// File: rtl/system_0_sysid_pkg.sv
// Shared definitions for the system ID slave, its boot-time checker and benches.
package system_0_sysid_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD_ID = 2'd1,
    ST_RD_TS = 2'd2,
    ST_FIN   = 2'd3
  } sysid_state_e;

  localparam logic        SYSID_ADDR_ID           = 1'b0;
  localparam logic        SYSID_ADDR_TS           = 1'b1;
  localparam logic [31:0] SYSID_DEFAULT_ID        = 32'd0;
  localparam logic [31:0] SYSID_DEFAULT_TIMESTAMP = 32'd1563511986;

endpackage

// File: rtl/system_0_sysid_checker_if.sv
// Avalon-MM read-only link between the checker (master) and the sysid control_slave.
interface system_0_sysid_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );
endinterface

// File: rtl/system_0_sysid_checker.sv
// Reads the sysid ID and timestamp words over Avalon-MM and checks them against
// build-time constants, flagging per-word matches or a stalled-read timeout.
module system_0_sysid_checker
  import system_0_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = SYSID_DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TIMESTAMP,
  parameter int unsigned TIMEOUT_CYCLES     = 256
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  system_0_sysid_checker_if.master avm,
  output logic                     busy,
  output logic                     done,
  output logic                     id_ok,
  output logic                     ts_ok,
  output logic                     timeout,
  output logic [31:0]              id_value,
  output logic [31:0]              ts_value
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  sysid_state_e     state_q, state_d;
  logic             read_q, read_d;
  logic             addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             id_ok_q, id_ok_d;
  logic             ts_ok_q, ts_ok_d;
  logic             timeout_q, timeout_d;
  logic [31:0]      id_value_q, id_value_d;
  logic [31:0]      ts_value_q, ts_value_d;

  logic accept;
  logic stall;

  assign accept = read_q & ~avm.avm_waitrequest;
  assign stall  = read_q &  avm.avm_waitrequest;

  always_comb begin
    state_d    = state_q;
    read_d     = read_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    timeout_d  = timeout_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          timeout_d = 1'b0;
          cnt_d     = CNT_LOAD;
          addr_d    = SYSID_ADDR_ID;
          read_d    = 1'b1;
          busy_d    = 1'b1;
          state_d   = ST_RD_ID;
        end
      end
      ST_RD_ID: begin
        // Accept is tested before the counter so a grant on the last allowed cycle wins.
        if (accept) begin
          id_value_d = avm.avm_readdata;
          id_ok_d    = (avm.avm_readdata == EXPECTED_ID);
          read_d     = 1'b0;
          state_d    = ST_RD_TS;
        end else if (stall) begin
          if (cnt_q == '0) begin
            read_d    = 1'b0;
            timeout_d = 1'b1;
            state_d   = ST_FIN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_RD_TS: begin
        // The first cycle here is the idle gap between the two reads.
        if (!read_q) begin
          addr_d = SYSID_ADDR_TS;
          read_d = 1'b1;
          cnt_d  = CNT_LOAD;
        end else if (accept) begin
          ts_value_d = avm.avm_readdata;
          ts_ok_d    = (avm.avm_readdata == EXPECTED_TIMESTAMP);
          read_d     = 1'b0;
          state_d    = ST_FIN;
        end else if (cnt_q == '0) begin
          read_d    = 1'b0;
          timeout_d = 1'b1;
          state_d   = ST_FIN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      read_q     <= 1'b0;
      addr_q     <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= '0;
      ts_value_q <= '0;
    end else begin
      state_q    <= state_d;
      read_q     <= read_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      timeout_q  <= timeout_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
    end
  end

  assign avm.avm_read    = read_q;
  assign avm.avm_address = addr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign id_ok           = id_ok_q;
  assign ts_ok           = ts_ok_q;
  assign timeout         = timeout_q;
  assign id_value        = id_value_q;
  assign ts_value        = ts_value_q;

endmodule

// File: tb/tb_system_0_sysid_checker.sv
// Scoreboard bench: two checkers (default and short timeout) against programmable
// zero-latency sysid slave models with per-word waitrequest stall counts.
module tb_system_0_sysid_checker;
  import system_0_sysid_pkg::*;

  localparam logic [31:0] TS = 32'd1563511986;

  typedef struct {
    int unsigned due;
    logic        id_ok;
    logic        ts_ok;
    logic        tmo;
    logic [31:0] idv;
    logic [31:0] tsv;
    logic        chk_id;
    logic        chk_ts;
  } exp_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic start0  = 1'b0;
  logic start1  = 1'b0;
  always #5 clock = ~clock;

  int unsigned cyc   = 0;
  int unsigned total = 0;
  int unsigned bad   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  system_0_sysid_checker_if bus0 ();
  system_0_sysid_checker_if bus1 ();

  logic        busy0, done0, id_ok0, ts_ok0, to0;
  logic        busy1, done1, id_ok1, ts_ok1, to1;
  logic [31:0] idv0, tsv0, idv1, tsv1;

  system_0_sysid_checker dut0 (
    .clock(clock), .reset_n(reset_n), .start(start0), .avm(bus0),
    .busy(busy0), .done(done0), .id_ok(id_ok0), .ts_ok(ts_ok0), .timeout(to0),
    .id_value(idv0), .ts_value(tsv0)
  );

  system_0_sysid_checker #(.TIMEOUT_CYCLES(8)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start1), .avm(bus1),
    .busy(busy1), .done(done1), .id_ok(id_ok1), .ts_ok(ts_ok1), .timeout(to1),
    .id_value(idv1), .ts_value(tsv1)
  );

  // Slave models: word registers plus a stall budget per address.
  logic [31:0] id_word0 = 32'd0, ts_word0 = TS, id_word1 = 32'd0, ts_word1 = TS;
  int unsigned stall_cfg0 [2];
  int unsigned stall_cfg1 [2];
  int unsigned stall_cnt0 = 0, stall_cnt1 = 0;

  assign bus0.avm_readdata    = bus0.avm_address ? ts_word0 : id_word0;
  assign bus1.avm_readdata    = bus1.avm_address ? ts_word1 : id_word1;
  assign bus0.avm_waitrequest = bus0.avm_read && (stall_cnt0 < stall_cfg0[bus0.avm_address]);
  assign bus1.avm_waitrequest = bus1.avm_read && (stall_cnt1 < stall_cfg1[bus1.avm_address]);

  always @(posedge clock) begin
    if (!bus0.avm_read) stall_cnt0 <= 0;
    else if (bus0.avm_waitrequest) stall_cnt0 <= stall_cnt0 + 1;
    if (!bus1.avm_read) stall_cnt1 <= 0;
    else if (bus1.avm_waitrequest) stall_cnt1 <= stall_cnt1 + 1;
  end

  exp_t q0[$];
  exp_t q1[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", name, act, want);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%b want=%b", name, act, want);
    end
  endtask

  task automatic cmp(input string t, input exp_t e, input logic bsy, input logic iok,
                     input logic tok, input logic tmo, input logic [31:0] idv,
                     input logic [31:0] tsv);
    check32({t, "_done_cycle"}, cyc, e.due);
    check1({t, "_busy_at_done"}, bsy, 1'b0);
    check1({t, "_id_ok"}, iok, e.id_ok);
    check1({t, "_ts_ok"}, tok, e.ts_ok);
    check1({t, "_timeout"}, tmo, e.tmo);
    if (e.chk_id) check32({t, "_id_value"}, idv, e.idv);
    if (e.chk_ts) check32({t, "_ts_value"}, tsv, e.tsv);
  endtask

  // Monitors: scoreboard pop on done, one-cycle done, address held through stalls.
  logic pd0 = 1'b0, pd1 = 1'b0, pr0 = 1'b0, pr1 = 1'b0, pa0 = 1'b0, pa1 = 1'b0;

  always @(negedge clock) begin
    if (reset_n) begin
      if (done0) begin
        if (q0.size() == 0) begin
          total++; bad++;
          $display("FAIL d0_spurious_done: done=1 want no done (nothing pending)");
        end else cmp("d0", q0.pop_front(), busy0, id_ok0, ts_ok0, to0, idv0, tsv0);
        check1("d0_done_one_cycle", pd0, 1'b0);
      end
      if (pr0) begin
        if (bus0.avm_read) check1("d0_addr_held", bus0.avm_address, pa0);
        else check1("d0_read_drop_is_timeout", to0, 1'b1);
      end
      if (done1) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL d1_spurious_done: done=1 want no done (nothing pending)");
        end else cmp("d1", q1.pop_front(), busy1, id_ok1, ts_ok1, to1, idv1, tsv1);
        check1("d1_done_one_cycle", pd1, 1'b0);
      end
      if (pr1) begin
        if (bus1.avm_read) check1("d1_addr_held", bus1.avm_address, pa1);
        else check1("d1_read_drop_is_timeout", to1, 1'b1);
      end
    end
    pd0 <= done0;
    pd1 <= done1;
    pr0 <= reset_n && bus0.avm_read && bus0.avm_waitrequest;
    pr1 <= reset_n && bus1.avm_read && bus1.avm_waitrequest;
    pa0 <= bus0.avm_address;
    pa1 <= bus1.avm_address;
  end

  // Called just after a negedge; start is sampled on the next posedge (cycle T).
  task automatic pulse(input int unsigned d, input int unsigned lat, input logic iok,
                       input logic tok, input logic tmo, input logic [31:0] idv,
                       input logic [31:0] tsv, input logic cid, input logic cts);
    exp_t e;
    e.due = cyc + 1 + lat;
    e.id_ok = iok; e.ts_ok = tok; e.tmo = tmo;
    e.idv = idv; e.tsv = tsv; e.chk_id = cid; e.chk_ts = cts;
    if (d == 0) begin q0.push_back(e); start0 = 1'b1; end
    else        begin q1.push_back(e); start1 = 1'b1; end
    @(negedge clock);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic kick(input int unsigned d);
    if (d == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_q(input int unsigned d, input int unsigned budget);
    int unsigned n = 0;
    while (((d == 0) ? q0.size() : q1.size()) != 0 && n < budget) begin
      @(negedge clock);
      #1;
      n++;
    end
    total++;
    if (((d == 0) ? q0.size() : q1.size()) != 0) begin
      bad++;
      $display("FAIL wait_done_d%0d: no done within %0d cycles, want done", d, budget);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, want test end");
    $fatal(1);
  end

  initial begin
    stall_cfg0[0] = 0; stall_cfg0[1] = 0;
    stall_cfg1[0] = 0; stall_cfg1[1] = 0;
    #12;
    check1("rst_read", bus0.avm_read, 1'b0);
    check1("rst_address", bus0.avm_address, 1'b0);
    check1("rst_busy", busy0, 1'b0);
    check1("rst_done", done0, 1'b0);
    check1("rst_id_ok", id_ok0, 1'b0);
    check1("rst_ts_ok", ts_ok0, 1'b0);
    check1("rst_timeout", to0, 1'b0);
    check32("rst_id_value", idv0, 32'd0);
    check32("rst_ts_value", tsv0, 32'd0);
    check1("rst_read_d1", bus1.avm_read, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    #1;

    // 1: matching words, no stalls
    pulse(0, 4, 1'b1, 1'b1, 1'b0, 32'd0, TS, 1'b1, 1'b1);
    wait_q(0, 40);
    // 2: wrong ID
    id_word0 = 32'h0000_0001;
    pulse(0, 4, 1'b0, 1'b1, 1'b0, 32'h0000_0001, TS, 1'b1, 1'b1);
    wait_q(0, 40);
    id_word0 = 32'd0;
    // timestamp differing only in the MSB
    ts_word0 = TS ^ 32'h8000_0000;
    pulse(0, 4, 1'b1, 1'b0, 1'b0, 32'd0, TS ^ 32'h8000_0000, 1'b1, 1'b1);
    wait_q(0, 40);
    ts_word0 = TS;
    // 3: ten stalled cycles on each read
    stall_cfg0[0] = 10; stall_cfg0[1] = 10;
    pulse(0, 24, 1'b1, 1'b1, 1'b0, 32'd0, TS, 1'b1, 1'b1);
    wait_q(0, 60);
    stall_cfg0[0] = 0;

    // 5: start during RD_TS ignored, then an immediate restart clears flags
    stall_cfg0[1] = 5;
    pulse(0, 9, 1'b1, 1'b1, 1'b0, 32'd0, TS, 1'b1, 1'b1);
    repeat (3) @(negedge clock);
    kick(0);
    wait_q(0, 40);
    stall_cfg0[1] = 0;
    pulse(0, 4, 1'b1, 1'b1, 1'b0, 32'd0, TS, 1'b1, 1'b1);
    check1("restart_clears_id_ok", id_ok0, 1'b0);
    check1("restart_clears_ts_ok", ts_ok0, 1'b0);
    check1("restart_busy", busy0, 1'b1);
    wait_q(0, 40);

    // 4: timeout on read 2 with TIMEOUT_CYCLES=8
    stall_cfg1[1] = 1000;
    pulse(1, 11, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0, 1'b1, 1'b0);
    wait_q(1, 40);
    // grant on the cycle the counter hits zero is not a timeout
    stall_cfg1[1] = 7;
    pulse(1, 11, 1'b1, 1'b1, 1'b0, 32'd0, TS, 1'b1, 1'b1);
    check1("restart_clears_timeout", to1, 1'b0);
    wait_q(1, 40);
    // timeout on read 1
    stall_cfg1[1] = 0; stall_cfg1[0] = 1000;
    pulse(1, 9, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
    wait_q(1, 40);
    stall_cfg1[0] = 0;

    // 6: reset during an RD_ID stall
    stall_cfg0[0] = 100;
    kick(0);
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check1("async_rst_read", bus0.avm_read, 1'b0);
    check1("async_rst_busy", busy0, 1'b0);
    check1("async_rst_done", done0, 1'b0);
    check32("async_rst_id_value", idv0, 32'd0);
    check32("async_rst_ts_value", tsv0, 32'd0);
    stall_cfg0[0] = 0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    check1("post_rst_done_quiet", done0, 1'b0);
    pulse(0, 4, 1'b1, 1'b1, 1'b0, 32'd0, TS, 1'b1, 1'b1);
    wait_q(0, 40);

    repeat (4) @(negedge clock);
    check32("q0_drained", q0.size(), 32'd0);
    check32("q1_drained", q1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
